fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit datapath. Owns the program counter (PC) and drives it to the instruction memory address input.
- Captures the instruction and address the memory returns into the IF/ID pipeline register for the decoder.
- Handles sequential fetch, branch/jump redirect, stall and flush.

Parameters:
- ADDR_W, 8, PC/instruction-memory address width in bits.
- INSTR_W, 16, instruction width in bits.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and IF/ID contents (hazard unit).
- flush  input  1  clear IF/ID valid (bubble) on next edge.
- redirect_valid  input  1  load PC from redirect_addr (taken branch/jump).
- redirect_addr  input  ADDR_W  redirect target.
- pc_out  output  ADDR_W  current PC, to memory addr_in.
- im_instr  input  INSTR_W  instruction from memory (combinational on pc_out).
- im_addr  input  ADDR_W  address echoed by memory addr_out.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  INSTR_W  registered instruction.
- if_id_pc  output  ADDR_W  registered address of that instruction.
- if_id_pc_next  output  ADDR_W  if_id_pc + 2, mod 256 (link/branch base).
- misalign  output  1  sticky: a redirect target had bit 0 set.
- halted  output  1  fetch halted (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC.
  - if_id_valid=0, if_id_instr=16'h0000, if_id_pc=0, if_id_pc_next=0.
  - misalign=0, halted=0.
- pc_out is the PC register directly. The memory is combinational, so im_instr/im_addr correspond to pc_out in the same cycle. Fetch latency is one cycle: PC to IF/ID.
- Instructions are word-aligned; PC steps by 2. Increment wraps 8'hFE -> 8'h00; there is no overflow flag.
- Per-edge priority, highest first:
  1. redirect_valid=1:
     - PC <= {redirect_addr[7:1],1'b0}.
     - IF/ID valid <= 0 (wrong-path instruction squashed).
     - Overrides stall and flush.
     - If redirect_addr[0]=1, misalign <= 1 (sticky until reset).
  2. flush=1 (no redirect):
     - IF/ID valid <= 0.
     - PC <= stall ? PC : PC+2.
  3. stall=1:
     - PC and all IF/ID fields hold, including valid.
  4. Otherwise:
     - PC <= PC+2.
     - if_id_instr <= im_instr, if_id_pc <= im_addr, if_id_pc_next <= im_addr+2, valid <= 1.
- When valid is cleared, if_id_instr is forced to 16'h0000 (NOP) and the pc fields hold.
- First edge after reset release: if_id_pc=8'h00, if_id_instr = word at 8'h00, PC=8'h02.
- Reset asserted mid-operation returns every output to its reset value immediately. No partial state survives.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A valid IF/ID instruction with opcode [15:12]=4'hE sets halted=1 on the following edge.
  - While halted: PC frozen, IF/ID valid <= 0 on every edge, redirect_valid/stall/flush ignored.
  - Only rst_n clears halted. The halt instruction itself is presented to decode for exactly one cycle.
- Not defined: halted is tied 0; opcode 4'hE is fetched like any other instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W=8, INSTR_W=16, PC_STEP=8'd2, RESET_PC=8'h00.
  - OPC_HALT=4'hE, NOP_INSTR=16'h0000.
  - Typedef if_id_t {valid, instr, pc, pc_next}.
- One sub-module, if_id_reg: the IF/ID register with hold/clear controls. The PC logic stays in fetch_unit.

Test Plan:
- Reset then free-run, memory word 8'h00=16'hF120, 8'h02=16'hF121 -> pc_out 00,02,04; if_id_instr F120 then F121; if_id_pc 00,02; if_id_pc_next 02,04; valid=1 from the first edge.
- stall high 3 cycles at PC=8'h06 -> pc_out stays 06, IF/ID frozen on the instruction from 04. Release -> fetch resumes at 06.
- redirect_valid with redirect_addr=8'h30 and stall=1 in the same cycle -> next pc_out=30, if_id_valid=0. Next edge: if_id_pc=30, valid=1.
- PC=8'hFE free-run -> next pc_out=00, if_id_pc_next=00 for the FE instruction. redirect_addr=8'h31 -> pc_out=30, misalign=1, and misalign stays 1 through later redirects.
- flush at PC=8'h10 -> if_id_valid=0, if_id_instr=0000, pc_out=12. Assert rst_n=0 mid-stream -> pc_out=00, valid=0 asynchronously.
- FETCH_HALT_DETECT_EN: word at 8'h36=16'hEFFF -> if_id_instr=EFFF valid for one cycle, then halted=1, pc_out frozen at 38, valid=0. A following redirect is ignored; only reset clears halted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and the IF/ID bundle for the 16-bit datapath.
// Consumed by fetch_unit and if_id_reg (FETCH_HALT_DETECT_EN uses OPC_HALT).
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP = 8'd2;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    localparam logic [3:0] OPC_HALT = 4'hE;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_next;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear squashes to a NOP bubble keeping the
// pc fields, hold freezes everything, otherwise the new bundle loads.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid   <= 1'b0;
            q.instr   <= NOP_INSTR;
            q.pc      <= '0;
            q.pc_next <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect/stall/flush, IF/ID capture.
// Define FETCH_HALT_DETECT_EN to freeze fetch after an opcode 4'hE instr.
module fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] im_instr,
    input  logic [ADDR_W-1:0]  im_addr,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_next,
    output logic               misalign,
    output logic               halted
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              mis_q;
    logic              mis_set;
    logic              ifid_hold;
    logic              ifid_clear;
    logic              halt_now;
    if_id_t            ifid_d;
    if_id_t            ifid_q;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q;
    logic halt_hit;

    // The halt instruction gets its one decode cycle, then fetch freezes.
    assign halt_hit = ifid_q.valid &&
                      (ifid_q.instr[INSTR_W-1 -: 4] == OPC_HALT);
    assign halt_now = halted_q | halt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halt_now = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_clear = 1'b0;
        mis_set    = 1'b0;
        if (halt_now) begin
            ifid_clear = 1'b1;
        end else if (redirect_valid) begin
            pc_d       = {redirect_addr[ADDR_W-1:1], 1'b0};
            ifid_clear = 1'b1;
            mis_set    = redirect_addr[0];
        end else if (flush) begin
            ifid_clear = 1'b1;
            if (!stall) begin
                pc_d = pc_q + PC_STEP;
            end
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (mis_set) begin
                mis_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ifid_d.valid   = 1'b1;
        ifid_d.instr   = im_instr;
        ifid_d.pc      = im_addr;
        ifid_d.pc_next = im_addr + PC_STEP;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (ifid_hold),
        .clear (ifid_clear),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign pc_out        = pc_q;
    assign misalign      = mis_q;
    assign if_id_valid   = ifid_q.valid;
    assign if_id_instr   = ifid_q.instr;
    assign if_id_pc      = ifid_q.pc;
    assign if_id_pc_next = ifid_q.pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: spec-level fetch model checked every cycle,
// plus directed vectors with literal expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [7:0]  pc_out;
    logic [15:0] im_instr;
    logic [7:0]  im_addr;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic [7:0]  if_id_pc_next;
    logic        misalign;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [7:0] a);
        case (a)
            8'h00:   return 16'hF120;
            8'h02:   return 16'hF121;
            8'h36:   return 16'hEFFF;
            default: return {4'h1, a, 4'h3};
        endcase
    endfunction

    assign im_instr = word_at(pc_out);
    assign im_addr  = pc_out;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc_out         (pc_out),
        .im_instr       (im_instr),
        .im_addr        (im_addr),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_next  (if_id_pc_next),
        .misalign       (misalign),
        .halted         (halted)
    );

    logic [7:0]  m_pc    = 8'h00;
    logic        m_valid = 1'b0;
    logic [15:0] m_instr = 16'h0000;
    logic [7:0]  m_ipc   = 8'h00;
    logic [7:0]  m_ipcn  = 8'h00;
    logic        m_mis   = 1'b0;
    logic        m_halt  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 8'h00;
            m_valid <= 1'b0;
            m_instr <= 16'h0000;
            m_ipc   <= 8'h00;
            m_ipcn  <= 8'h00;
            m_mis   <= 1'b0;
            m_halt  <= 1'b0;
        end else begin
`ifdef FETCH_HALT_DETECT_EN
            if (m_halt || (m_valid && m_instr[15:12] == 4'hE)) begin
                m_halt  <= 1'b1;
                m_valid <= 1'b0;
                m_instr <= 16'h0000;
            end else
`endif
            if (redirect_valid) begin
                m_pc    <= redirect_addr & 8'hFE;
                m_valid <= 1'b0;
                m_instr <= 16'h0000;
                if (redirect_addr[0]) m_mis <= 1'b1;
            end else if (flush) begin
                m_valid <= 1'b0;
                m_instr <= 16'h0000;
                if (!stall) m_pc <= m_pc + 8'd2;
            end else if (!stall) begin
                m_pc    <= m_pc + 8'd2;
                m_instr <= word_at(m_pc);
                m_ipc   <= m_pc;
                m_ipcn  <= m_pc + 8'd2;
                m_valid <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("m.pc_out", pc_out, m_pc);
            chk("m.valid", if_id_valid, m_valid);
            chk("m.instr", if_id_instr, m_instr);
            chk("m.if_pc", if_id_pc, m_ipc);
            chk("m.if_pcn", if_id_pc_next, m_ipcn);
            chk("m.misalign", misalign, m_mis);
            chk("m.halted", halted, m_halt);
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic redir(input logic [7:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        go = 1'b1;
        #2;
        chk("rst.pc", pc_out, 8'h00);
        chk("rst.valid", if_id_valid, 1'b0);
        chk("rst.instr", if_id_instr, 16'h0000);
        chk("rst.pcn", if_id_pc_next, 8'h00);
        chk("rst.halted", halted, 1'b0);
        cyc();
        rst_n = 1'b1;

        cyc();
        chk("run1.pc", pc_out, 8'h02);
        chk("run1.instr", if_id_instr, 16'hF120);
        chk("run1.ifpc", if_id_pc, 8'h00);
        chk("run1.pcn", if_id_pc_next, 8'h02);
        chk("run1.valid", if_id_valid, 1'b1);
        cyc();
        chk("run2.pc", pc_out, 8'h04);
        chk("run2.instr", if_id_instr, 16'hF121);
        chk("run2.pcn", if_id_pc_next, 8'h04);
        cyc();
        chk("run3.pc", pc_out, 8'h06);

        stall = 1'b1;
        cyc(3);
        chk("stall.pc", pc_out, 8'h06);
        chk("stall.ifpc", if_id_pc, 8'h04);
        chk("stall.instr", if_id_instr, 16'h1043);
        chk("stall.valid", if_id_valid, 1'b1);
        stall = 1'b0;
        cyc();
        chk("resume.ifpc", if_id_pc, 8'h06);
        chk("resume.pc", pc_out, 8'h08);

        stall = 1'b1;
        redir(8'h30);
        stall = 1'b0;
        chk("rdst.pc", pc_out, 8'h30);
        chk("rdst.valid", if_id_valid, 1'b0);
        cyc();
        chk("rdst2.ifpc", if_id_pc, 8'h30);
        chk("rdst2.valid", if_id_valid, 1'b1);

        redir(8'hFC);
        cyc(2);
        chk("wrap.ifpc", if_id_pc, 8'hFE);
        chk("wrap.pcn", if_id_pc_next, 8'h00);
        chk("wrap.pc", pc_out, 8'h00);
        redir(8'h31);
        chk("mis.pc", pc_out, 8'h30);
        chk("mis.flag", misalign, 1'b1);
        redir(8'h20);
        chk("mis.sticky", misalign, 1'b1);
        chk("mis.pc2", pc_out, 8'h20);

        redir(8'h10);
        flush = 1'b1;
        cyc();
        chk("flush.valid", if_id_valid, 1'b0);
        chk("flush.instr", if_id_instr, 16'h0000);
        chk("flush.pc", pc_out, 8'h12);
        stall = 1'b1;
        cyc();
        chk("flst.pc", pc_out, 8'h12);
        flush = 1'b0;
        stall = 1'b0;
        cyc(2);
        chk("post.pc", pc_out, 8'h16);
        chk("post.ifpc", if_id_pc, 8'h14);

        #2 rst_n = 1'b0;
        #1;
        chk("arst.pc", pc_out, 8'h00);
        chk("arst.valid", if_id_valid, 1'b0);
        chk("arst.mis", misalign, 1'b0);
        cyc();
        rst_n = 1'b1;

        redir(8'h34);
        cyc(2);
        chk("h.instr", if_id_instr, 16'hEFFF);
        chk("h.ifpc", if_id_pc, 8'h36);
        chk("h.pc", pc_out, 8'h38);
        cyc();
`ifdef FETCH_HALT_DETECT_EN
        chk("h1.halted", halted, 1'b1);
        chk("h1.valid", if_id_valid, 1'b0);
        chk("h1.pc", pc_out, 8'h38);
        redir(8'h50);
        chk("h2.pc", pc_out, 8'h38);
        chk("h2.halted", halted, 1'b1);
`else
        chk("h1.halted", halted, 1'b0);
        chk("h1.ifpc", if_id_pc, 8'h38);
        chk("h1.pc", pc_out, 8'h3A);
        redir(8'h50);
        chk("h2.pc", pc_out, 8'h50);
`endif
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("hr.halted", halted, 1'b0);
        chk("hr.pc", pc_out, 8'h00);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("hr.run", pc_out, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
